mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one unified memory port between instruction fetch (IF) and load/store (LS) in the RISC-V core.
//  Sits between fetch/control logic and the memory; the datapath stalls while its request is pending.
//  LS has fixed priority, with an anti-starvation limit for fetch; a timeout guards a hung memory.
// PARAMETERS
//  AW             32  address width
//  DW             32  data width
//  MAX_LS_STREAK  4   max consecutive LS grants while IF waits (1..15)
//  TIMEOUT        64  BUSY cycles without mem_ack before abort; 0 = disabled
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  if_req     in   1      fetch request; held with if_addr until if_gnt
//  if_addr    in   AW     fetch address
//  if_gnt     out  1      fetch accepted (combinational, IDLE only)
//  if_done    out  1      1-cycle pulse: if_rdata valid
//  if_rdata   out  DW     fetched instruction
//  ls_req     in   1      load/store request; fields held until ls_gnt
//  ls_we      in   1      1 = store, 0 = load
//  ls_addr    in   AW     data address
//  ls_wdata   in   DW     store data
//  ls_be      in   DW/8   byte enables
//  ls_gnt     out  1      LS accepted (combinational, IDLE only)
//  ls_done    out  1      1-cycle pulse: load data valid / store complete
//  ls_rdata   out  DW     load data (0 for stores)
//  mem_req    out  1      memory request, held until mem_ack or abort
//  mem_we     out  1      memory write enable
//  mem_addr   out  AW     memory address
//  mem_wdata  out  DW     memory write data
//  mem_be     out  DW/8   memory byte enables
//  mem_ack    in   1      memory completion; sampled only while mem_req=1
//  mem_rdata  in   DW     read data, valid with mem_ack
//  err        out  1      1-cycle pulse on timeout abort
//  busy       out  1      state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; every output and register is 0, including ls_streak and the timeout counter.
//  FSM states: IDLE, BUSY_IF, BUSY_LS.
//  IDLE, no request: stay in IDLE. mem_ack is ignored.
//  IDLE, only ls_req: ls_gnt=1; latch we/addr/wdata/be; next state BUSY_LS.
//  IDLE, only if_req: if_gnt=1; latch if_addr; mem_we=0, mem_be=all 1s; next state BUSY_IF.
//  IDLE, both requests: LS wins unless ls_streak==MAX_LS_STREAK, in which case IF wins.
//  ls_streak: +1 on each LS grant while if_req=1; cleared on an IF grant; saturates.
//  Only one of if_gnt/ls_gnt is ever high in a cycle; neither is high outside IDLE.
//  mem_* outputs are registered; mem_req=1 in BUSY_* from the cycle after the grant.
//  mem_ack in cycle T: capture mem_rdata; owner done=1 at T+1; state returns to IDLE at T+1.
//  The IDLE at T+1 may grant again, so requests run back-to-back.
//  Minimum latency: grant T0, mem_req T1, mem_ack T1, done T2.
//  Timeout: counter clears on entry to BUSY; +1 per BUSY cycle without ack.
//  On reaching TIMEOUT: drop mem_req; next cycle owner done=1 with rdata=0, err=1; then IDLE.
//  mem_ack in the same cycle the count reaches TIMEOUT: the ack wins; no err.
//  ls_rdata is 0 on store completion; done of the non-owner is always 0.
//  rdata holds its last value between done pulses.
//  rst mid-transfer: immediately IDLE, mem_req=0, no done/err pulse; the request is lost.
//  Requester fields changing before gnt: the value sampled in the grant cycle is used.
// TESTING
//  1. Single fetch, if_addr=0x100, mem_ack 1 cycle after mem_req, rdata=0x00500093
//     -> if_gnt T0, mem_req T1..T1, if_done T2, if_rdata=0x00500093.
//  2. Store ls_addr=0x2000, wdata=0xDEADBEEF, be=4'b1111, ack after 3 cycles
//     -> mem_we=1, mem_req high 3 cycles, ls_done once, ls_rdata=0.
//  3. if_req and ls_req continuously high, ack immediate, MAX_LS_STREAK=4
//     -> grant order LS,LS,LS,LS,IF repeating; never two grants in one cycle.
//  4. TIMEOUT=8, mem_ack never
//     -> mem_req high 8 cycles, then err=1 and owner done=1, rdata=0, busy falls.
//  5. Reset asserted 2 cycles into BUSY_LS
//     -> mem_req=0 and busy=0 asynchronously; no ls_done; ls_streak=0.
//  6. Back-to-back loads 0x10, 0x14, ack immediate
//     -> second ls_gnt in the same cycle as the first ls_done; ls_rdata matches each mem_rdata.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between the fetch and load/store units,
// the shared memory port and the arbiter that multiplexes them.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            if_req;
    logic [AW-1:0]   if_addr;
    logic            if_gnt;
    logic            if_done;
    logic [DW-1:0]   if_rdata;

    logic            ls_req;
    logic            ls_we;
    logic [AW-1:0]   ls_addr;
    logic [DW-1:0]   ls_wdata;
    logic [DW/8-1:0] ls_be;
    logic            ls_gnt;
    logic            ls_done;
    logic [DW-1:0]   ls_rdata;

    logic            mem_req;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW/8-1:0] mem_be;
    logic            mem_ack;
    logic [DW-1:0]   mem_rdata;

    logic            err;
    logic            busy;

    modport slave (
        input  if_req, if_addr,
        input  ls_req, ls_we, ls_addr, ls_wdata, ls_be,
        input  mem_ack, mem_rdata,
        output if_gnt, if_done, if_rdata,
        output ls_gnt, ls_done, ls_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output err, busy
    );

    modport master (
        output if_req, if_addr,
        output ls_req, ls_we, ls_addr, ls_wdata, ls_be,
        output mem_ack, mem_rdata,
        input  if_gnt, if_done, if_rdata,
        input  ls_gnt, ls_done, ls_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  err, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// LS has priority, bounded by a streak limit; a timeout aborts hung accesses.
module mem_port_arbiter #(
    parameter int AW            = 32,
    parameter int DW            = 32,
    parameter int MAX_LS_STREAK = 4,
    parameter int TIMEOUT       = 64
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    localparam int BW = DW / 8;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TO_LAST =
        (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
    localparam logic [3:0] STREAK_MAX = 4'(MAX_LS_STREAK);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_LS = 2'd2
    } state_e;

    state_e          state_q;
    logic [3:0]      streak_q;
    logic [TW-1:0]   to_q;
    logic            mem_req_q;
    logic            mem_we_q;
    logic [AW-1:0]   mem_addr_q;
    logic [DW-1:0]   mem_wdata_q;
    logic [BW-1:0]   mem_be_q;
    logic            if_done_q;
    logic            ls_done_q;
    logic            err_q;
    logic [DW-1:0]   if_rdata_q;
    logic [DW-1:0]   ls_rdata_q;

    logic ls_win;
    logic if_gnt_d;
    logic ls_gnt_d;
    logic to_hit;

    // IF overrides LS priority once LS has won MAX_LS_STREAK times in a row.
    always_comb begin
        ls_win   = bus.ls_req && !(bus.if_req && streak_q == STREAK_MAX);
        ls_gnt_d = (state_q == IDLE) && ls_win;
        if_gnt_d = (state_q == IDLE) && bus.if_req && !ls_win;
        to_hit   = (TIMEOUT != 0) && (to_q == TO_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            to_q        <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            if_done_q   <= 1'b0;
            ls_done_q   <= 1'b0;
            err_q       <= 1'b0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
        end else begin
            if_done_q <= 1'b0;
            ls_done_q <= 1'b0;
            err_q     <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (ls_gnt_d) begin
                        state_q     <= BUSY_LS;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= bus.ls_we;
                        mem_addr_q  <= bus.ls_addr;
                        mem_wdata_q <= bus.ls_wdata;
                        mem_be_q    <= bus.ls_be;
                        to_q        <= '0;
                        if (bus.if_req && streak_q != STREAK_MAX)
                            streak_q <= streak_q + 4'd1;
                    end else if (if_gnt_d) begin
                        state_q     <= BUSY_IF;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= bus.if_addr;
                        mem_wdata_q <= '0;
                        mem_be_q    <= '1;
                        to_q        <= '0;
                        streak_q    <= '0;
                    end
                end
                BUSY_IF, BUSY_LS: begin
                    // An ack in the timeout cycle still completes normally.
                    if (bus.mem_ack || to_hit) begin
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                        err_q     <= !bus.mem_ack;
                        if (state_q == BUSY_IF) begin
                            if_done_q  <= 1'b1;
                            if_rdata_q <= bus.mem_ack ? bus.mem_rdata : '0;
                        end else begin
                            ls_done_q  <= 1'b1;
                            ls_rdata_q <= (bus.mem_ack && !mem_we_q)
                                          ? bus.mem_rdata : '0;
                        end
                    end else begin
                        to_q <= to_q + 1'b1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.if_gnt    = if_gnt_d;
    assign bus.ls_gnt    = ls_gnt_d;
    assign bus.if_done   = if_done_q;
    assign bus.ls_done   = ls_done_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.ls_rdata  = ls_rdata_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.err       = err_q;
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, store, priority/streak,
// back-to-back loads, timeout abort and reset mid-transfer.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_port_arbiter #(
        .AW(32),
        .DW(32),
        .MAX_LS_STREAK(4),
        .TIMEOUT(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int          nvec     = 0;
    int          nerr     = 0;
    int          ack_lat  = 1;
    logic        fixed_en = 1'b0;
    logic [31:0] fixed_rd = '0;
    int          rcnt;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Memory model: acks in the ack_lat-th cycle of mem_req (0 = never).
    initial begin : responder
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        rcnt          = 0;
        forever begin
            @(negedge clk);
            if (bus.mem_req === 1'b1) begin
                rcnt++;
                bus.mem_ack = (ack_lat != 0) && (rcnt == ack_lat);
            end else begin
                rcnt        = 0;
                bus.mem_ack = 1'b0;
            end
            bus.mem_rdata = fixed_en ? fixed_rd
                                     : (bus.mem_addr ^ 32'h5A5A_0000);
        end
    end

    initial begin : main
        int nreq;
        int ndone;
        int ng;
        logic both;
        logic hit;

        bus.if_req   = 1'b0;
        bus.if_addr  = '0;
        bus.ls_req   = 1'b0;
        bus.ls_we    = 1'b0;
        bus.ls_addr  = '0;
        bus.ls_wdata = '0;
        bus.ls_be    = '0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst busy", bus.busy, 0);
        chk("rst mem_req", bus.mem_req, 0);
        chk("rst if_done", bus.if_done, 0);
        chk("rst ls_done", bus.ls_done, 0);
        chk("rst err", bus.err, 0);
        chk("rst if_rdata", bus.if_rdata, 0);
        chk("rst ls_rdata", bus.ls_rdata, 0);
        @(negedge clk);
        rst = 1'b0;

        // single fetch
        @(negedge clk);
        ack_lat     = 1;
        fixed_en    = 1'b1;
        fixed_rd    = 32'h0050_0093;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h100;
        #1;
        chk("t1 if_gnt", bus.if_gnt, 1);
        chk("t1 ls_gnt", bus.ls_gnt, 0);
        chk("t1 mem_req T0", bus.mem_req, 0);
        @(negedge clk);
        bus.if_req = 1'b0;
        #1;
        chk("t1 mem_req T1", bus.mem_req, 1);
        chk("t1 mem_addr", bus.mem_addr, 32'h100);
        chk("t1 mem_we", bus.mem_we, 0);
        chk("t1 mem_be", bus.mem_be, 4'hF);
        @(negedge clk);
        #1;
        chk("t1 if_done", bus.if_done, 1);
        chk("t1 if_rdata", bus.if_rdata, 32'h0050_0093);
        chk("t1 mem_req T2", bus.mem_req, 0);
        chk("t1 busy T2", bus.busy, 0);
        chk("t1 ls_done", bus.ls_done, 0);
        @(negedge clk);
        #1;
        chk("t1 if_done T3", bus.if_done, 0);
        chk("t1 if_rdata hold", bus.if_rdata, 32'h0050_0093);

        // store with 3-cycle ack
        @(negedge clk);
        ack_lat      = 3;
        fixed_rd     = 32'h1234_5678;
        bus.ls_req   = 1'b1;
        bus.ls_we    = 1'b1;
        bus.ls_addr  = 32'h2000;
        bus.ls_wdata = 32'hDEAD_BEEF;
        bus.ls_be    = 4'hF;
        #1;
        chk("t2 ls_gnt", bus.ls_gnt, 1);
        nreq  = 0;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.ls_req = 1'b0;
            #1;
            if (i == 0) begin
                chk("t2 mem_we", bus.mem_we, 1);
                chk("t2 mem_addr", bus.mem_addr, 32'h2000);
                chk("t2 mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
                chk("t2 mem_be", bus.mem_be, 4'hF);
            end
            if (bus.mem_req) nreq++;
            if (bus.ls_done) begin
                ndone++;
                chk("t2 ls_rdata", bus.ls_rdata, 0);
            end
        end
        chk("t2 mem_req cycles", nreq, 3);
        chk("t2 ls_done count", ndone, 1);

        // both requesters continuously: LS x4 then IF
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        ack_lat  = 1;
        fixed_en = 1'b0;
        both     = 1'b0;
        ng       = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (c == 0) begin
                bus.if_req   = 1'b1;
                bus.if_addr  = 32'h300;
                bus.ls_req   = 1'b1;
                bus.ls_we    = 1'b0;
                bus.ls_addr  = 32'h400;
            end
            #1;
            if (bus.if_gnt && bus.ls_gnt) both = 1'b1;
            if (bus.if_gnt || bus.ls_gnt) begin
                if (ng < 10)
                    chk($sformatf("t3 grant%0d", ng),
                        {30'b0, bus.if_gnt, bus.ls_gnt},
                        (ng % 5 == 4) ? 32'd2 : 32'd1);
                ng++;
            end
        end
        chk("t3 double grant", both, 0);
        chk("t3 grant count", ng, 12);
        @(negedge clk);
        bus.if_req = 1'b0;
        bus.ls_req = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("t3 drained", bus.busy, 0);

        // back-to-back loads
        @(negedge clk);
        ack_lat     = 1;
        bus.ls_req  = 1'b1;
        bus.ls_we   = 1'b0;
        bus.ls_addr = 32'h10;
        bus.ls_be   = 4'hF;
        #1;
        chk("t6 gnt0", bus.ls_gnt, 1);
        @(negedge clk);
        bus.ls_addr = 32'h14;
        #1;
        chk("t6 mem_addr0", bus.mem_addr, 32'h10);
        chk("t6 mem_we", bus.mem_we, 0);
        @(negedge clk);
        #1;
        chk("t6 done0", bus.ls_done, 1);
        chk("t6 rdata0", bus.ls_rdata, 32'h5A5A_0010);
        chk("t6 gnt1 with done0", bus.ls_gnt, 1);
        @(negedge clk);
        bus.ls_req = 1'b0;
        #1;
        chk("t6 mem_addr1", bus.mem_addr, 32'h14);
        chk("t6 done gap", bus.ls_done, 0);
        @(negedge clk);
        #1;
        chk("t6 done1", bus.ls_done, 1);
        chk("t6 rdata1", bus.ls_rdata, 32'h5A5A_0014);

        // timeout with no ack
        @(negedge clk);
        ack_lat     = 0;
        bus.ls_req  = 1'b1;
        bus.ls_we   = 1'b0;
        bus.ls_addr = 32'h40;
        #1;
        chk("t4 ls_gnt", bus.ls_gnt, 1);
        nreq = 0;
        hit  = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge clk);
            bus.ls_req = 1'b0;
            #1;
            if (bus.mem_req) begin
                nreq++;
            end else begin
                hit = 1'b1;
                chk("t4 err", bus.err, 1);
                chk("t4 ls_done", bus.ls_done, 1);
                chk("t4 ls_rdata", bus.ls_rdata, 0);
                chk("t4 busy", bus.busy, 0);
                chk("t4 if_done", bus.if_done, 0);
            end
        end
        chk("t4 timed out", hit, 1);
        chk("t4 mem_req cycles", nreq, 8);
        @(negedge clk);
        #1;
        chk("t4 err pulse", bus.err, 0);

        // reset in the middle of a store
        @(negedge clk);
        bus.ls_req  = 1'b1;
        bus.ls_we   = 1'b1;
        bus.ls_addr = 32'h80;
        #1;
        chk("t5 ls_gnt", bus.ls_gnt, 1);
        @(negedge clk);
        bus.ls_req = 1'b0;
        @(negedge clk);
        #1;
        chk("t5 busy before", bus.busy, 1);
        rst = 1'b1;
        #1;
        chk("t5 mem_req async", bus.mem_req, 0);
        chk("t5 busy async", bus.busy, 0);
        @(negedge clk);
        rst   = 1'b0;
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            if (bus.ls_done || bus.err) ndone++;
        end
        chk("t5 no done/err", ndone, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
